// File: rtl/kogge_sub16_pipe_if.sv
// kogge_sub16_pipe_if: operand/result valid-ready bus for the pipelined subtractor.
// master drives operands and consumer ready; slave is the subtractor side.
interface kogge_sub16_pipe_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             Z;
    logic             N;
    logic             V;

    modport master (
        output in_valid, A, B, Bin, out_ready,
        input  in_ready, out_valid, D, Bout, Z, N, V
    );

    modport slave (
        input  in_valid, A, B, Bin, out_ready,
        output in_ready, out_valid, D, Bout, Z, N, V
    );
endinterface

// File: rtl/kogge_sub16_pipe.sv
// kogge_sub16_pipe: two-stage Kogge-Stone subtract-with-borrow (A + ~B + ~Bin) with
// valid/ready flow control; prefix levels are split across the stage-1 register.
module kogge_sub16_pipe #(
    parameter int WIDTH     = 16,
    parameter int S1_LEVELS = 2
) (
    input logic               clk,
    input logic               rst,
    kogge_sub16_pipe_if.slave bus
);
    localparam int LEVELS = $clog2(WIDTH);

    logic             adv1, adv2;
    logic [WIDTH-1:0] g0, p0, g_fin, c, dif, unused_p;
    logic             s1_valid_d, s1_valid_q, s1_cin_d, s1_cin_q;
    logic             s1_am_d, s1_am_q, s1_bm_d, s1_bm_q;
    logic [WIDTH-1:0] s1_g_d, s1_g_q, s1_p_d, s1_p_q, s1_pv_d, s1_pv_q;
    logic             s2_valid_d, s2_valid_q, bout_d, bout_q, z_d, z_q, n_d, n_q, v_d, v_q;
    logic [WIDTH-1:0] d_d, d_q;

    assign g0 = bus.A & ~bus.B;
    assign p0 = bus.A ^ ~bus.B;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int DIST = 2 ** k;
        logic [WIDTH-1:0] g_in, p_in, g_out, p_out;
        // the carry-in is folded into column 0, so its group propagate is zero
        if (k == 0) begin : g_src
            assign g_in = {g0[WIDTH-1:1], g0[0] | (p0[0] & ~bus.Bin)};
            assign p_in = {p0[WIDTH-1:1], 1'b0};
        end else if (k == S1_LEVELS) begin : g_src
            assign g_in = s1_g_q;
            assign p_in = s1_p_q;
        end else begin : g_src
            assign g_in = g_lvl[k-1].g_out;
            assign p_in = g_lvl[k-1].p_out;
        end
        for (genvar i = 0; i < WIDTH; i++) begin : g_col
            if (i < DIST) begin : g_pass
                assign g_out[i] = g_in[i];
                assign p_out[i] = p_in[i];
            end else if (i < 2 * DIST) begin : g_gray
                assign g_out[i] = g_in[i] | (p_in[i] & g_in[i-DIST]);
                assign p_out[i] = 1'b0;
            end else begin : g_black
                assign g_out[i] = g_in[i] | (p_in[i] & g_in[i-DIST]);
                assign p_out[i] = p_in[i] & p_in[i-DIST];
            end
        end
    end

    assign g_fin    = g_lvl[LEVELS-1].g_out;
    assign unused_p = g_lvl[LEVELS-1].p_out;
    assign c        = {g_fin[WIDTH-2:0], s1_cin_q};
    assign dif      = s1_pv_q ^ c;

    always_comb begin
        adv2       = ~s2_valid_q | bus.out_ready;
        adv1       = ~s1_valid_q | adv2;
        s1_valid_d = adv1 ? bus.in_valid : s1_valid_q;
        s1_g_d     = adv1 ? g_lvl[S1_LEVELS-1].g_out : s1_g_q;
        s1_p_d     = adv1 ? g_lvl[S1_LEVELS-1].p_out : s1_p_q;
        s1_pv_d    = adv1 ? p0 : s1_pv_q;
        s1_cin_d   = adv1 ? ~bus.Bin : s1_cin_q;
        s1_am_d    = adv1 ? bus.A[WIDTH-1] : s1_am_q;
        s1_bm_d    = adv1 ? bus.B[WIDTH-1] : s1_bm_q;
        s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
        d_d        = adv2 ? dif : d_q;
        bout_d     = adv2 ? ~g_fin[WIDTH-1] : bout_q;
        z_d        = adv2 ? ~|dif : z_q;
        n_d        = adv2 ? dif[WIDTH-1] : n_q;
        v_d        = adv2 ? (s1_am_q ^ s1_bm_q) & (dif[WIDTH-1] ^ s1_am_q) : v_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_g_q     <= '0;
            s1_p_q     <= '0;
            s1_pv_q    <= '0;
            s1_cin_q   <= 1'b0;
            s1_am_q    <= 1'b0;
            s1_bm_q    <= 1'b0;
            s2_valid_q <= 1'b0;
            d_q        <= '0;
            bout_q     <= 1'b0;
            z_q        <= 1'b0;
            n_q        <= 1'b0;
            v_q        <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_g_q     <= s1_g_d;
            s1_p_q     <= s1_p_d;
            s1_pv_q    <= s1_pv_d;
            s1_cin_q   <= s1_cin_d;
            s1_am_q    <= s1_am_d;
            s1_bm_q    <= s1_bm_d;
            s2_valid_q <= s2_valid_d;
            d_q        <= d_d;
            bout_q     <= bout_d;
            z_q        <= z_d;
            n_q        <= n_d;
            v_q        <= v_d;
        end
    end

    assign bus.in_ready  = adv1;
    assign bus.out_valid = s2_valid_q;
    assign bus.D         = d_q;
    assign bus.Bout      = bout_q;
    assign bus.Z         = z_q;
    assign bus.N         = n_q;
    assign bus.V         = v_q;
endmodule

// File: tb/tb_kogge_sub16_pipe.sv
// tb_kogge_sub16_pipe: directed and randomized checks of the pipelined subtractor
// against an arithmetic reference model and an in-order scoreboard.
module tb_kogge_sub16_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    kogge_sub16_pipe_if #(.WIDTH(16)) bus ();
    kogge_sub16_pipe #(.WIDTH(16), .S1_LEVELS(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // {D, Bout, Z, N, V}
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b, input logic bin);
        logic [16:0] r;
        r = {1'b0, a} - {1'b0, b} - {16'd0, bin};
        return {r[15:0], r[16], r[15:0] == 16'd0, r[15], (a[15] != b[15]) && (r[15] != a[15])};
    endfunction

    function automatic logic [19:0] obs();
        return {bus.D, bus.Bout, bus.Z, bus.N, bus.V};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.Bin = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++;
        if (obs() !== 20'h0) begin errors++; $display("FAIL reset_payload: got %h expected 00000", obs()); end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_directed();
        logic [15:0] va[5] = '{16'h0005, 16'h0000, 16'h0000, 16'h8000, 16'h1234};
        logic [15:0] vb[5] = '{16'h0003, 16'h0001, 16'h0000, 16'h0001, 16'h1234};
        logic        vc[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [19:0] ve[5] = '{{16'h0002, 4'b0000}, {16'hFFFF, 4'b1010}, {16'hFFFF, 4'b1010},
                               {16'h7FFF, 4'b0001}, {16'h0000, 4'b0100}};
        bus.out_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            bus.in_valid = 1'b1;
            bus.A = va[t];
            bus.B = vb[t];
            bus.Bin = vc[t];
            tick();
            bus.in_valid = 1'b0;
            checks++;
            if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL directed%0d_early: out_valid got %b expected 0", t, bus.out_valid); end
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || obs() !== ve[t])
                begin errors++; $display("FAIL directed%0d: valid=%b payload got %h expected %h", t, bus.out_valid, obs(), ve[t]); end
        end
        tick();
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int got = 0;
        int first = -1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.B = '0;
        bus.Bin = 1'b0;
        bus.A = 16'd1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (bus.in_ready) acc++;
            tick();
            bus.A = 16'(acc + 1);
        end
        checks++;
        if (acc != 2) begin errors++; $display("FAIL bp_accepted: got %0d expected 2", acc); end
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready: got %b expected 0", bus.in_ready); end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.D !== 16'h0001)
            begin errors++; $display("FAIL bp_hold: valid=%b D got %h expected 0001", bus.out_valid, bus.D); end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b expected 1", bus.in_ready); end
        for (int cyc = 0; cyc < 12 && got < 4; cyc++) begin
            if (bus.out_valid) begin
                if (first < 0) first = cyc;
                checks++;
                if (bus.D !== 16'(got + 1) || cyc != first + got)
                    begin errors++; $display("FAIL bp_drain%0d: D got %h expected %h at cycle %0d", got, bus.D, 16'(got + 1), cyc); end
                got++;
            end
            if (bus.in_valid && bus.in_ready) acc++;
            tick();
            bus.in_valid = acc < 4;
            bus.A = 16'(acc + 1);
        end
        bus.in_valid = 1'b0;
        checks++;
        if (got != 4) begin errors++; $display("FAIL bp_count: got %0d results expected 4", got); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.A = 16'h00AA;
        bus.B = 16'h0001;
        bus.Bin = 1'b0;
        tick();
        bus.A = 16'h00BB;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
            begin errors++; $display("FAIL mid_full: valid=%b in_ready=%b expected 1/0", bus.out_valid, bus.in_ready); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.D !== 16'h0)
            begin errors++; $display("FAIL mid_async: valid=%b D=%h expected 0/0000", bus.out_valid, bus.D); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", bus.in_ready); end
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.A = 16'h0009;
        bus.B = 16'h0004;
        bus.Bin = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_early: out_valid got %b expected 0", bus.out_valid); end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || obs() !== {16'h0004, 4'b0000})
            begin errors++; $display("FAIL mid_first: valid=%b payload got %h expected 00040", bus.out_valid, obs()); end
        tick();
    endtask

    task automatic test_random();
        logic [19:0] q[$];
        logic [19:0] held = '0;
        logic [19:0] exp;
        logic        stall = 1'b0;
        int          beats_in = 0;
        int          beats_out = 0;
        int          cyc = 0;
        int          r;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        while (beats_out < 10000 && cyc < 60000) begin
            @(negedge clk);
            if (stall) begin
                checks++;
                if (bus.out_valid !== 1'b1 || obs() !== held)
                    begin errors++; $display("FAIL rnd_stall: valid=%b payload got %h expected %h", bus.out_valid, obs(), held); end
            end
            stall = bus.out_valid && !bus.out_ready;
            held = obs();
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_extra: got %h expected no result", obs());
                end else begin
                    exp = q.pop_front();
                    if (obs() !== exp) begin errors++; $display("FAIL rnd_result%0d: got %h expected %h", beats_out, obs(), exp); end
                end
                beats_out++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.A, bus.B, bus.Bin));
                beats_in++;
            end
            tick();
            r = $urandom_range(7);
            bus.in_valid = (beats_in < 10000) && ($urandom_range(3) != 0);
            bus.A = r == 0 ? 16'h0000 : r == 1 ? 16'hFFFF : r == 2 ? 16'h8000 : 16'($urandom);
            bus.B = r == 3 ? bus.A : r == 4 ? 16'h7FFF : 16'($urandom);
            bus.Bin = 1'($urandom);
            bus.out_ready = $urandom_range(3) != 0;
            cyc++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (beats_out != 10000) begin errors++; $display("FAIL rnd_count: got %0d results expected 10000", beats_out); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
